deser_param: RTL and testbench

- Parametrised serial-to-parallel deserializer: next generation of the team's bit-to-byte shifter.
- Collects WIDTH bits from a qualified serial stream and presents each completed word through a valid/ready output register.
- Adds configurable bit order, backpressure with overrun detection, and a flush that aborts a partial word.
- Sits between a serial line front-end and a word-oriented consumer (FIFO or register file).

---
 rtl/deser_pkg.sv | 33 +++
 rtl/deser_out_slot.sv | 85 ++++++++
 rtl/deser_param.sv | 120 ++++++++++++
 tb/tb_deser_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the deser_param deserializer and its output slot.
//   - bit_order_e : which end of the word the first received serial bit lands in
//   - PARITY_EN   : 1 when the build carries a trailing even-parity bit per frame
//   - frame_len() : serial bits per frame for a given word width
//   - cnt_width() : bit counter width able to hold 0..frame_len()
// Build option: define DESER_PARITY_EN to append a parity bit to every frame.
// -----------------------------------------------------------------------------
package deser_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

`ifdef DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits that make up one frame: the data bits, plus the parity bit
  // when parity is built in.
  function automatic int frame_len(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(frame_len(width) + 1);
  endfunction

endpackage

// File: rtl/deser_out_slot.sv
// -----------------------------------------------------------------------------
// deser_out_slot
// Single-entry valid/ready output register for the deserializer.
//
// Handshake: o_vld=1 means o_word holds a word the consumer has not taken yet;
// the word is taken on a rising edge where o_vld=1 and i_rdy=1. i_rdy is
// ignored while o_vld=0. The slot counts as free when it is empty or is being
// emptied in the same cycle, so a new word can replace a departing one with
// no bubble.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous active-low reset
//   i_load     in   a completed word is offered this cycle
//   i_word     in   the completed word
//   i_par_err  in   parity result belonging to i_word
//   i_rdy      in   consumer ready
//   i_flush    in   clears the sticky overrun flag (word state is kept)
//   o_word     out  last accepted word, held until replaced
//   o_vld      out  o_word is unconsumed
//   o_par_err  out  parity result loaded together with o_word
//   o_overrun  out  sticky: an offered word was dropped because the slot was full
// -----------------------------------------------------------------------------
module deser_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_par_err,
  input  logic             i_rdy,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_word,
  output logic             o_vld,
  output logic             o_par_err,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_vld;
  logic             r_par_err;
  logic             r_overrun;

  logic             w_free;
  logic             w_take;
  logic             w_drop;

  assign w_free = !r_vld || i_rdy;
  assign w_take = i_load && w_free;
  assign w_drop = i_load && !w_free;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_word    <= '0;
      r_vld     <= 1'b0;
      r_par_err <= 1'b0;
    end else if (w_take) begin
      r_word    <= i_word;
      r_vld     <= 1'b1;
      r_par_err <= i_par_err;
    end else if (r_vld && i_rdy) begin
      // Consumed with nothing to replace it; the word value stays visible.
      r_vld <= 1'b0;
    end
  end

  // Flush never coincides with a load (the top discards the bit), so the
  // clear and the set cannot fight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overrun <= 1'b0;
    end else if (i_flush) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_word    = r_word;
  assign o_vld     = r_vld;
  assign o_par_err = r_par_err;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/deser_param.sv
// -----------------------------------------------------------------------------
// deser_param
// Parametrised serial-to-parallel deserializer. Qualified serial bits are
// shifted into a buffer; when a full frame has been accepted the word is
// offered to a single-entry valid/ready output slot. A full slot drops the
// new word and raises the sticky overrun flag. flush aborts a partial word.
//
// Build option: DESER_PARITY_EN appends an even-parity bit to each frame. The
// parity bit is checked but not stored; parity_err reports the result for
// the word on word_out. Without the option parity_err is tied to 0.
//
// Parameters:
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: first received bit lands in word_out[WIDTH-1]
//              0: first received bit lands in word_out[0]
//
// Ports:
//   clk         in   rising-edge clock
//   rst_b       in   asynchronous active-low reset
//   bit_in      in   serial data bit, sampled when bit_vld=1
//   bit_vld     in   qualifies bit_in
//   flush       in   synchronous abort of the partial word
//   word_out    out  last completed word, held until replaced
//   word_vld    out  word_out holds an unconsumed word
//   word_rdy    in   consumer accepts word_out when word_vld=1
//   overrun     out  sticky: a completed word was dropped
//   parity_err  out  parity result for word_out
// -----------------------------------------------------------------------------
module deser_param
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int         FRAME = frame_len(WIDTH);
  localparam int         CNT_W = cnt_width(WIDTH);
  localparam bit_order_e ORDER = MSB_FIRST ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

  logic [WIDTH-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_store;
  logic             w_complete;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_par_err;

  // A bit that arrives together with flush is discarded.
  assign w_accept   = bit_vld && !flush;
  assign w_last     = (r_cnt == CNT_W'(FRAME - 1));
  assign w_complete = w_accept && w_last;

  generate
    if (ORDER == ORDER_MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_buf[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign w_shifted = {bit_in, r_buf[WIDTH-1:1]};
    end
  endgenerate

`ifdef DESER_PARITY_EN
  // The last bit of a frame is the parity bit: it is folded into the check
  // but never shifted in, so the buffer already holds the finished word.
  assign w_store   = w_accept && !w_last;
  assign w_word    = r_buf;
  assign w_par_err = (^r_buf) ^ bit_in;
`else
  // The last bit is a data bit, so the offered word is the post-shift value.
  assign w_store   = w_accept;
  assign w_word    = w_shifted;
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_store) begin
        r_buf <= w_shifted;
      end
      // The buffer is not cleared on completion; the next frame overwrites it.
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  deser_out_slot #(
    .WIDTH (WIDTH)
  ) u_out_slot (
    .clk       (clk),
    .rst_b     (rst_b),
    .i_load    (w_complete),
    .i_word    (w_word),
    .i_par_err (w_par_err),
    .i_rdy     (word_rdy),
    .i_flush   (flush),
    .o_word    (word_out),
    .o_vld     (word_vld),
    .o_par_err (parity_err),
    .o_overrun (overrun)
  );

endmodule

// File: tb/tb_deser_param.sv
// -----------------------------------------------------------------------------
// tb_deser_param
// Two deserializers (MSB-first and LSB-first) share one serial stream. The
// reference model keeps the received bits of the current frame in a queue and
// builds the expected word for each bit order from that queue when the frame
// is full; a one-entry slot model tracks valid, overrun and parity.
// -----------------------------------------------------------------------------
module tb_deser_param;

  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int FRAME_TB = W + 1;
`else
  localparam int FRAME_TB = W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic bit_in = 1'b0;
  logic bit_vld = 1'b0;
  logic flush = 1'b0;
  logic word_rdy = 1'b0;

  logic [W-1:0] m_word, l_word;
  logic         m_vld, l_vld, m_ovr, l_ovr, m_par, l_par;

  deser_param #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_b(rst_b), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
    .word_out(m_word), .word_vld(m_vld), .word_rdy(word_rdy),
    .overrun(m_ovr), .parity_err(m_par)
  );

  deser_param #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_b(rst_b), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
    .word_out(l_word), .word_vld(l_vld), .word_rdy(word_rdy),
    .overrun(l_ovr), .parity_err(l_par)
  );

  // ---------------- reference model / scoreboard ----------------
  logic         bit_q[$];         // bits of the frame in progress, in arrival order
  logic [W-1:0] exp_q[$];         // words delivered to the MSB-first slot, newest last
  logic [W-1:0] exp_word_m = '0;
  logic [W-1:0] exp_word_l = '0;
  logic         exp_vld = 1'b0;
  logic         exp_ovr = 1'b0;
  logic         exp_par = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bit_q.delete();
    exp_q.delete();
    exp_word_m = '0;
    exp_word_l = '0;
    exp_vld = 1'b0;
    exp_ovr = 1'b0;
    exp_par = 1'b0;
  endtask

  // Applies one clock edge worth of behaviour given the inputs of that cycle.
  task automatic model_update(input logic b, input logic v, input logic f, input logic r);
    logic         done;
    logic [W-1:0] wm, wl;
    logic         par;
    done = 1'b0;
    wm = '0;
    wl = '0;
    par = 1'b0;
    if (f) begin
      bit_q.delete();
    end else if (v) begin
      bit_q.push_back(b);
      if (bit_q.size() == FRAME_TB) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bit_q[i];
          wl[i] = bit_q[i];
        end
        for (int i = 0; i < FRAME_TB; i++) par = par ^ bit_q[i];
`ifndef DESER_PARITY_EN
        par = 1'b0;
`endif
        bit_q.delete();
      end
    end
    if (done && (!exp_vld || r)) begin
      exp_word_m = wm;
      exp_word_l = wl;
      exp_par = par;
      exp_vld = 1'b1;
      exp_q.push_back(wm);
    end else if (done) begin
      exp_ovr = 1'b1;
    end else if (exp_vld && r) begin
      exp_vld = 1'b0;
    end
    if (f) exp_ovr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".m_word"}, m_word, exp_word_m);
    chk({tag, ".l_word"}, l_word, exp_word_l);
    chk({tag, ".m_vld"}, m_vld, exp_vld);
    chk({tag, ".l_vld"}, l_vld, exp_vld);
    chk({tag, ".m_ovr"}, m_ovr, exp_ovr);
    chk({tag, ".l_ovr"}, l_ovr, exp_ovr);
    chk({tag, ".m_par"}, m_par, exp_par);
    chk({tag, ".l_par"}, l_par, exp_par);
    if (exp_q.size() > 0) chk({tag, ".sb_word"}, m_word, exp_q[$]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic b, input logic v, input logic f, input logic r);
    bit_in = b;
    bit_vld = v;
    flush = f;
    word_rdy = r;
    @(posedge clk);
    model_update(b, v, f, r);
    #1;
    check_all("cyc");
  endtask

  // Sends data MSB of the value first; gap=1 inserts an idle cycle after each bit.
  task automatic send_word(input logic [W-1:0] data, input logic par_flip,
                           input logic gap, input logic rdy);
    for (int i = 0; i < FRAME_TB; i++) begin
      logic b;
      if (i < W) b = data[W-1-i];
      else       b = (^data) ^ par_flip;
      cycle(b, 1'b1, 1'b0, rdy);
      if (gap) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_b = 1'b1;

    // Consecutive bits, consumer ready.
    send_word(8'hB2, 1'b0, 1'b0, 1'b1);
    chk("b2_msb", m_word, 8'hB2);
    chk("b2_lsb", l_word, 8'h4D);
    chk("b2_vld", m_vld, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2_vld_one_cycle", m_vld, 1'b0);
    chk("b2_no_ovr", m_ovr, 1'b0);

    // Gapped bits.
    send_word(8'hB2, 1'b0, 1'b1, 1'b1);
    chk("gap_lsb", l_word, 8'h4D);
    chk("gap_msb", m_word, 8'hB2);

    // Backpressure and overrun.
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("ovr_word_kept", m_word, 8'hB2);
    chk("ovr_set", m_ovr, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_consumed", m_vld, 1'b0);
    chk("ovr_sticky", m_ovr, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Flush mid-word with a completed word pending.
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_vld_held", m_vld, 1'b1);
    chk("flush_word_held", m_word, 8'h5A);
    chk("flush_ovr_clr", m_ovr, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("flush_next_word", m_word, 8'hA5);

    // Asynchronous reset between edges after 5 bits, with a word pending.
    for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_word", m_word, 8'h00);
    #2;
    rst_b = 1'b1;
    send_word(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("after_rst_word", m_word, 8'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DESER_PARITY_EN
    send_word(8'hB2, 1'b0, 1'b0, 1'b1);
    chk("par_good", m_par, 1'b0);
    chk("par_good_word", m_word, 8'hB2);
    send_word(8'hB2, 1'b1, 1'b0, 1'b1);
    chk("par_bad", m_par, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic: random bits, gaps, backpressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
